// File: rtl/uart_block_rx.sv
// uart_block_rx: receive-side UART deframer. Recovers 8N1 bytes from the serial
// line and packs NBYTES of them into one block. The first byte received lands in
// the top byte of odata.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   RX         asynchronous serial input, idle high
//   odata      last complete block (8*NBYTES bits); changes only with datavalid
//   datavalid  one-cycle pulse when odata has just been updated
//   frame_err  one-cycle pulse when a stop bit was sampled low
//   busy       a byte is in flight or a block is partly filled
module uart_block_rx #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned NBYTES       = 10,
    parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX,
    output logic [8*NBYTES-1:0]   odata,
    output logic                  datavalid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TmrW  = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned CntW  = $clog2(NBYTES + 1);

    localparam logic [BaudW-1:0] BitLast  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] HalfLast = BaudW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TmrW-1:0]  TmoLast  = TmrW'(TIMEOUT_CLKS - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(NBYTES);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q;
    logic                  rx_meta_q;
    logic                  rs_q;       // synchronised RX
    logic                  rs_prev_q;  // rs_q delayed one cycle, for edge detect
    logic [BaudW-1:0]      baud_q;
    logic [2:0]            bit_idx_q;
    logic [7:0]            shift_q;
    logic [CntW-1:0]       cnt_q;
    logic [TmrW-1:0]       tmr_q;
    logic [8*NBYTES-1:0]   blk_q;      // assembly buffer, only copied to odata when full

    logic start_edge;
    assign start_edge = rs_prev_q & ~rs_q;

    assign busy = (state_q != StIdle) | (cnt_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            blk_q     <= '0;
            odata     <= '0;
            datavalid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rs_q      <= rx_meta_q;
            rs_prev_q <= rs_q;
            datavalid <= 1'b0;
            frame_err <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (cnt_q == CntFull) begin
                        odata     <= blk_q;
                        datavalid <= 1'b1;
                        cnt_q     <= '0;
                        tmr_q     <= '0;
                    end else if (cnt_q != '0) begin
                        // Timeout is evaluated before the start edge so that it wins;
                        // the byte then starting lands in slot 0.
                        if (tmr_q == TmoLast) begin
                            cnt_q <= '0;
                            tmr_q <= '0;
                        end else begin
                            tmr_q <= tmr_q + TmrW'(1);
                        end
                    end else begin
                        tmr_q <= '0;
                    end
                    if (start_edge) begin
                        state_q <= StStart;
                        baud_q  <= '0;
                        tmr_q   <= '0;
                    end
                end

                StStart: begin
                    if (baud_q == HalfLast) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        // Line high at mid start bit: glitch, not a frame.
                        state_q   <= rs_q ? StIdle : StData;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end

                StData: begin
                    if (baud_q == BitLast) begin
                        baud_q    <= '0;
                        shift_q   <= {rs_q, shift_q[7:1]};  // LSB first
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end

                StStop: begin
                    if (baud_q == BitLast) begin
                        baud_q  <= '0;
                        state_q <= StIdle;
                        if (rs_q) begin
                            for (int i = 0; i < int'(NBYTES); i++) begin
                                if (cnt_q == CntW'(i)) begin
                                    blk_q[8*(int'(NBYTES)-1-i) +: 8] <= shift_q;
                                end
                            end
                            cnt_q <= cnt_q + CntW'(1);
                        end else begin
                            frame_err <= 1'b1;
                            cnt_q     <= '0;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_block_rx.sv
module tb_uart_block_rx;

    localparam int unsigned Cpb  = 16;
    localparam int unsigned Nb   = 10;
    localparam int unsigned Tmo  = 320;

    logic          clk;
    logic          rst;
    logic          RX;
    logic [79:0]   odata;
    logic          datavalid;
    logic          frame_err;
    logic          busy;

    int tests_run;
    int tests_failed;
    int dv_total;
    int fe_total;
    int bad_upd;
    logic [79:0] prev_odata;

    uart_block_rx #(
        .CLKS_PER_BIT (Cpb),
        .NBYTES       (Nb),
        .TIMEOUT_CLKS (Tmo)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .odata     (odata),
        .datavalid (datavalid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters (cycles high, so a wide pulse counts more than once) and a
    // watch for odata moving without datavalid.
    initial begin
        dv_total   = 0;
        fe_total   = 0;
        bad_upd    = 0;
        prev_odata = '0;
    end
    always @(negedge clk) begin
        if (!rst) begin
            if (datavalid === 1'b1) dv_total = dv_total + 1;
            if (frame_err === 1'b1) fe_total = fe_total + 1;
            if (odata !== prev_odata && datavalid !== 1'b1) bad_upd = bad_upd + 1;
        end
        prev_odata = odata;
    end

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        RX = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (Cpb) @(negedge clk);
        end
        RX = stop_bit;
        repeat (Cpb) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic send_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(first + 8'(i), 1'b1);
        end
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RX  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (odata !== 80'h0) begin
            tests_failed++;
            $display("FAIL reset_odata: got %h expected %h", odata, 80'h0);
        end
        tests_run++;
        if (datavalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_datavalid: got %b expected 0", datavalid);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_frame_err: got %b expected 0", frame_err);
        end
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_block();
        int dv0;
        int fe0;
        dv0 = dv_total;
        fe0 = fe_total;
        send_byte(8'h01, 1'b1);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL block_busy_partial: got %b expected 1", busy);
        end
        send_seq(8'h02, 9);
        idle(20);
        tests_run++;
        if (dv_total - dv0 !== 1) begin
            tests_failed++;
            $display("FAIL block_dv_count: got %0d expected 1", dv_total - dv0);
        end
        tests_run++;
        if (odata !== 80'h0102030405060708090A) begin
            tests_failed++;
            $display("FAIL block_odata: got %h expected %h", odata, 80'h0102030405060708090A);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL block_busy_after: got %b expected 0", busy);
        end
        tests_run++;
        if (fe_total - fe0 !== 0) begin
            tests_failed++;
            $display("FAIL block_fe_count: got %0d expected 0", fe_total - fe0);
        end
    endtask

    task automatic test_glitch();
        int dv0;
        int fe0;
        dv0 = dv_total;
        fe0 = fe_total;
        @(negedge clk);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        idle(30);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy: got %b expected 0", busy);
        end
        tests_run++;
        if ((dv_total - dv0) + (fe_total - fe0) !== 0) begin
            tests_failed++;
            $display("FAIL glitch_pulses: got dv=%0d fe=%0d expected 0/0",
                     dv_total - dv0, fe_total - fe0);
        end
        tests_run++;
        if (odata !== 80'h0102030405060708090A) begin
            tests_failed++;
            $display("FAIL glitch_odata: got %h expected %h", odata, 80'h0102030405060708090A);
        end
        // A stored glitch byte would shift the next block by one slot.
        send_seq(8'h31, 10);
        idle(20);
        tests_run++;
        if (odata !== 80'h3132333435363738393A) begin
            tests_failed++;
            $display("FAIL glitch_next_block: got %h expected %h",
                     odata, 80'h3132333435363738393A);
        end
    endtask

    task automatic test_frame_err();
        int dv0;
        int fe0;
        dv0 = dv_total;
        fe0 = fe_total;
        send_seq(8'h21, 3);
        send_byte(8'h55, 1'b0);
        idle(Cpb);
        tests_run++;
        if (fe_total - fe0 !== 1) begin
            tests_failed++;
            $display("FAIL ferr_pulse_count: got %0d expected 1", fe_total - fe0);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ferr_busy: got %b expected 0", busy);
        end
        send_seq(8'hA0, 10);
        idle(20);
        tests_run++;
        if (dv_total - dv0 !== 1) begin
            tests_failed++;
            $display("FAIL ferr_dv_count: got %0d expected 1", dv_total - dv0);
        end
        tests_run++;
        if (odata !== 80'hA0A1A2A3A4A5A6A7A8A9) begin
            tests_failed++;
            $display("FAIL ferr_odata: got %h expected %h", odata, 80'hA0A1A2A3A4A5A6A7A8A9);
        end
    endtask

    task automatic test_timeout();
        int dv0;
        dv0 = dv_total;
        send_seq(8'hE1, 4);
        idle(Cpb);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_busy_before: got %b expected 1", busy);
        end
        idle(330 - Cpb);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_busy_after: got %b expected 0", busy);
        end
        send_seq(8'h11, 10);
        idle(20);
        tests_run++;
        if (dv_total - dv0 !== 1) begin
            tests_failed++;
            $display("FAIL tmo_dv_count: got %0d expected 1", dv_total - dv0);
        end
        tests_run++;
        if (odata !== 80'h1112131415161718191A) begin
            tests_failed++;
            $display("FAIL tmo_odata: got %h expected %h", odata, 80'h1112131415161718191A);
        end
    endtask

    task automatic test_reset_mid();
        int dv0;
        send_seq(8'h71, 6);
        // Seventh byte: start bit, bits 0..4, then half of bit 5.
        @(negedge clk);
        RX = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            RX = i[0];
            repeat (Cpb) @(negedge clk);
        end
        RX = 1'b1;
        repeat (Cpb / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (odata !== 80'h0 || datavalid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got odata=%h dv=%b fe=%b busy=%b expected all 0",
                     odata, datavalid, frame_err, busy);
        end
        RX = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        dv0 = dv_total;
        send_seq(8'hC0, 10);
        idle(20);
        tests_run++;
        if (dv_total - dv0 !== 1) begin
            tests_failed++;
            $display("FAIL midrst_dv_count: got %0d expected 1", dv_total - dv0);
        end
        tests_run++;
        if (odata !== 80'hC0C1C2C3C4C5C6C7C8C9) begin
            tests_failed++;
            $display("FAIL midrst_odata: got %h expected %h", odata, 80'hC0C1C2C3C4C5C6C7C8C9);
        end
    endtask

    task automatic test_odata_hold();
        tests_run++;
        if (bad_upd !== 0) begin
            tests_failed++;
            $display("FAIL odata_hold: got %0d updates without datavalid expected 0", bad_upd);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        RX           = 1'b1;
        test_reset();
        test_block();
        test_glitch();
        test_frame_err();
        test_timeout();
        test_reset_mid();
        test_odata_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
